// File: rtl/spi_ss_pkg.sv
// Shared types, SPI mode encodings and the request-legality rule for the multi-CS controller.
package spi_ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } ss_state_e;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;

    // A request is serviceable only with a non-zero bit period, a non-empty frame and an existing slave.
    function automatic logic req_legal(input logic [31:0] div,
                                       input logic [31:0] len,
                                       input logic [31:0] sel,
                                       input logic [31:0] num_ss);
        return (div != 32'd0) && (len != 32'd0) && (sel < num_ss);
    endfunction

endpackage

// File: rtl/ss_frame_timer.sv
// Phase timer shared by SETUP/XFER/HOLD: clear restarts at 0, run advances by one.
// o_last is combinational and flags the final cycle of the current phase.
module ss_frame_timer
    import spi_ss_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == (i_target - CNT_W'(1)));

endmodule

// File: rtl/spi_multi_ss_controller.sv
// Drives one of NUM_SS active-low chip selects per SPI frame with setup/hold padding and frame chaining.
// CS, receive strobe and error strobe are registered; tip_o follows the registered CS directly.
module spi_multi_ss_controller
    import spi_ss_pkg::*;
#(
    parameter int NUM_SS    = 4,
    parameter int SEL_W     = 2,
    parameter int DIV_W     = 12,
    parameter int LEN_W     = 5,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              mstr_i,
    input  logic              spiswai_i,
    input  logic [1:0]        spi_mode_i,
    input  logic              send_data_i,
    input  logic [SEL_W-1:0]  ss_sel_i,
    input  logic [DIV_W-1:0]  baudratedivisor_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic              cont_i,
    output logic [NUM_SS-1:0] ss_o,
    output logic              tip_o,
    output logic              receive_data_o,
    output logic              err_o
);

    localparam int TGT_W = DIV_W + LEN_W;

    ss_state_e         r_state, w_state_nxt;
    logic [NUM_SS-1:0] r_ss, w_ss_nxt, w_ss_dec;
    logic              r_rx, w_rx_nxt;
    logic              r_err, w_err_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [TGT_W-1:0]  r_target, w_target_nxt, w_req_target, w_tmr_target;
    logic              w_en, w_req, w_legal, w_chain;
    logic              w_clr, w_run, w_last;

    assign w_en    = mstr_i & ~spiswai_i & ((spi_mode_i == SPI_RUN) | (spi_mode_i == SPI_WAIT));
    assign w_req   = send_data_i & w_en;
    assign w_legal = req_legal(32'(baudratedivisor_i), 32'(frame_len_i), 32'(ss_sel_i), 32'(NUM_SS));
    assign w_req_target = TGT_W'(frame_len_i) * TGT_W'(baudratedivisor_i);
    assign w_chain = cont_i & w_req & w_legal & (ss_sel_i == r_sel);

    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel_i == SEL_W'(i)) begin
                w_ss_dec[i] = 1'b0;
            end
        end
    end

    ss_frame_timer #(
        .CNT_W (TGT_W)
    ) u_timer (
        .i_clk    (PCLK),
        .i_rst_n  (PRESET_n),
        .i_clr    (w_clr),
        .i_run    (w_run),
        .i_target (w_tmr_target),
        .o_last   (w_last)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESET_n) begin
            r_state  <= IDLE;
            r_ss     <= '1;
            r_rx     <= 1'b0;
            r_err    <= 1'b0;
            r_sel    <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ss     <= w_ss_nxt;
            r_rx     <= w_rx_nxt;
            r_err    <= w_err_nxt;
            r_sel    <= w_sel_nxt;
            r_target <= w_target_nxt;
        end
    end

    // Every phase change clears the timer so each phase counts from zero.
    always_comb begin
        w_state_nxt  = r_state;
        w_ss_nxt     = r_ss;
        w_rx_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_sel_nxt    = r_sel;
        w_target_nxt = r_target;
        w_tmr_target = r_target;
        w_clr        = 1'b0;
        w_run        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (w_req) begin
                    if (w_legal) begin
                        w_sel_nxt    = ss_sel_i;
                        w_target_nxt = w_req_target;
                        w_ss_nxt     = w_ss_dec;
                        w_state_nxt  = (SETUP_CYC > 0) ? SETUP : XFER;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            SETUP: begin
                w_tmr_target = TGT_W'(SETUP_CYC);
                if (!w_en) begin
                    w_state_nxt = IDLE;
                    w_ss_nxt    = '1;
                    w_clr       = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = XFER;
                    w_clr       = 1'b1;
                end else begin
                    w_run = 1'b1;
                end
            end
            XFER: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                    w_ss_nxt    = '1;
                    w_clr       = 1'b1;
                end else if (w_last) begin
                    w_rx_nxt = 1'b1;
                    w_clr    = 1'b1;
                    if (w_chain) begin
                        w_target_nxt = w_req_target;
                    end else if (HOLD_CYC > 0) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_ss_nxt    = '1;
                    end
                end else begin
                    w_run = 1'b1;
                end
            end
            HOLD: begin
                w_tmr_target = TGT_W'(HOLD_CYC);
                if (!w_en || w_last) begin
                    w_state_nxt = IDLE;
                    w_ss_nxt    = '1;
                    w_clr       = 1'b1;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ss_nxt    = '1;
                w_clr       = 1'b1;
            end
        endcase
    end

    assign ss_o           = r_ss;
    assign tip_o          = ~&r_ss;
    assign receive_data_o = r_rx;
    assign err_o          = r_err;

endmodule

// File: tb/tb_spi_multi_ss_controller.sv
// Directed bench: two controller instances (setup/hold 1/1 and 0/0) sharing stimulus.
module tb_spi_multi_ss_controller;

    logic        PCLK      = 1'b0;
    logic        PRESET_n  = 1'b0;
    logic        mstr      = 1'b1;
    logic        spiswai   = 1'b0;
    logic [1:0]  mode      = 2'b00;
    logic        send      = 1'b0;
    logic [2:0]  sel       = 3'd2;
    logic [11:0] div       = 12'd4;
    logic [4:0]  len       = 5'd8;
    logic        cont      = 1'b0;
    logic        use_b     = 1'b0;

    logic [3:0]  ss_a, ss_b, ss_m;
    logic        tip_a, tip_b, tip_m;
    logic        rx_a, rx_b, rx_m;
    logic        err_a, err_b;

    int checks = 0;
    int errors = 0;

    int low_cnt, tip_cnt, bad_ss, rx_cnt, rx_first, rx_last, last_low;
    int act;

    assign ss_m  = use_b ? ss_b  : ss_a;
    assign tip_m = use_b ? tip_b : tip_a;
    assign rx_m  = use_b ? rx_b  : rx_a;

    always #5 PCLK = ~PCLK;

    spi_multi_ss_controller #(
        .NUM_SS(4), .SEL_W(3), .DIV_W(12), .LEN_W(5), .SETUP_CYC(1), .HOLD_CYC(1)
    ) u_a (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .mstr_i(mstr), .spiswai_i(spiswai),
        .spi_mode_i(mode), .send_data_i(send), .ss_sel_i(sel),
        .baudratedivisor_i(div), .frame_len_i(len), .cont_i(cont),
        .ss_o(ss_a), .tip_o(tip_a), .receive_data_o(rx_a), .err_o(err_a)
    );

    spi_multi_ss_controller #(
        .NUM_SS(4), .SEL_W(3), .DIV_W(12), .LEN_W(5), .SETUP_CYC(0), .HOLD_CYC(0)
    ) u_b (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .mstr_i(mstr), .spiswai_i(spiswai),
        .spi_mode_i(mode), .send_data_i(send), .ss_sel_i(sel),
        .baudratedivisor_i(div), .frame_len_i(len), .cont_i(cont),
        .ss_o(ss_b), .tip_o(tip_b), .receive_data_o(rx_b), .err_o(err_b)
    );

    task automatic chk_eq(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick;
    endtask

    // Cycle 1 is the first cycle after the edge that accepted the request.
    task automatic run_win(input int ncyc, input int drop_at, input int swai_at, input int rst_at);
        low_cnt = 0; tip_cnt = 0; bad_ss = 0; rx_cnt = 0;
        rx_first = 0; rx_last = 0; last_low = 0;
        for (int n = 1; n <= ncyc; n++) begin
            if (n == drop_at) send = 1'b0;
            if (n == swai_at) spiswai = 1'b1;
            if (swai_at > 0 && n == swai_at + 1) spiswai = 1'b0;
            if (n == rst_at) PRESET_n = 1'b0;
            if (rst_at > 0 && n == rst_at + 1) PRESET_n = 1'b1;
            if (ss_m != 4'hF) begin
                low_cnt++;
                last_low = n;
                if (ss_m != 4'b1011) bad_ss++;
            end
            if (tip_m) tip_cnt++;
            if (rx_m) begin
                rx_cnt++;
                if (rx_first == 0) rx_first = n;
                rx_last = n;
            end
            tick;
        end
    endtask

    task automatic err_case(input string tag, input logic [11:0] d, input logic [4:0] l, input logic [2:0] s);
        div = d; len = l; sel = s; send = 1'b1;
        tick;
        send = 1'b0;
        chk_eq({tag, "_err"}, int'(err_a), 1);
        chk_eq({tag, "_ss"},  int'(ss_a), 15);
        chk_eq({tag, "_tip"}, int'(tip_a), 0);
        tick;
        chk_eq({tag, "_err_clr"}, int'(err_a), 0);
        div = 12'd4; len = 5'd8; sel = 3'd2;
        idle(2);
    endtask

    initial begin
        tick; tick;
        chk_eq("rst_ss",  int'(ss_a), 15);
        chk_eq("rst_tip", int'(tip_a), 0);
        chk_eq("rst_rx",  int'(rx_a), 0);
        chk_eq("rst_err", int'(err_a), 0);
        PRESET_n = 1'b1;
        idle(3);

        // Single frame: 1 setup + 32 bit cycles + 1 hold.
        send = 1'b1; tick;
        run_win(60, 1, 0, 0);
        chk_eq("t1_low", low_cnt, 34);
        chk_eq("t1_contig", last_low, 34);
        chk_eq("t1_tip", tip_cnt, 34);
        chk_eq("t1_badss", bad_ss, 0);
        chk_eq("t1_rxcnt", rx_cnt, 1);
        chk_eq("t1_rxcyc", rx_first, 34);
        chk_eq("t1_end_ss", int'(ss_a), 15);
        idle(5);

        // Two chained frames with CS held between them.
        cont = 1'b1; send = 1'b1; tick;
        run_win(90, 35, 0, 0);
        cont = 1'b0;
        chk_eq("t2_low", low_cnt, 66);
        chk_eq("t2_contig", last_low, 66);
        chk_eq("t2_tip", tip_cnt, 66);
        chk_eq("t2_badss", bad_ss, 0);
        chk_eq("t2_rxcnt", rx_cnt, 2);
        chk_eq("t2_rx1", rx_first, 34);
        chk_eq("t2_rx2", rx_last, 66);
        idle(5);

        // Stop-in-wait abort in cycle 10, then a fresh frame.
        send = 1'b1; tick;
        run_win(40, 1, 10, 0);
        chk_eq("t3_low", low_cnt, 10);
        chk_eq("t3_rxcnt", rx_cnt, 0);
        idle(5);
        send = 1'b1; tick;
        run_win(40, 1, 0, 0);
        chk_eq("t3_redo_low", low_cnt, 34);
        chk_eq("t3_redo_rx", rx_first, 34);
        idle(5);

        err_case("t4_div0", 12'd0, 5'd8, 3'd2);
        err_case("t4_sel5", 12'd4, 5'd8, 3'd5);
        err_case("t4_len0", 12'd4, 5'd0, 3'd2);

        // Reset in cycle 20 of a frame.
        send = 1'b1; tick;
        run_win(50, 1, 0, 20);
        chk_eq("t5_low", low_cnt, 20);
        chk_eq("t5_rxcnt", rx_cnt, 0);
        chk_eq("t5_end_ss", int'(ss_a), 15);
        idle(5);

        // Disabled modes: no CS activity, no error.
        mode = 2'b10; send = 1'b1; act = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (ss_a != 4'hF || err_a || tip_a) act++;
        end
        chk_eq("t6_stop_mode", act, 0);
        mode = 2'b00; mstr = 1'b0; act = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (ss_a != 4'hF || err_a || tip_a) act++;
        end
        chk_eq("t6_no_mstr", act, 0);
        send = 1'b0; mstr = 1'b1;
        idle(5);

        // Zero setup/hold, one-bit frame at div 1.
        use_b = 1'b1; div = 12'd1; len = 5'd1; send = 1'b1; tick;
        run_win(10, 1, 0, 0);
        chk_eq("t6b_low", low_cnt, 1);
        chk_eq("t6b_tip", tip_cnt, 1);
        chk_eq("t6b_rxcnt", rx_cnt, 1);
        chk_eq("t6b_rxcyc", rx_first, 2);
        chk_eq("t6b_end_ss", int'(ss_b), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_multi_ss_controller.md
Name: spi_multi_ss_controller

Overview:
Parametrised successor to the single-line slave-select generator. It drives NUM_SS active-low chip selects, one at a time, for master-mode SPI transfers. Frame length is programmable, and each frame has configurable CS setup and hold times. Continuous back-to-back frames keep CS low between frames. It sits between the APB register block and the SPI shifter/baud generator, and gives the shifter the tip_o and receive_data_o qualifiers.

Parameters:
NUM_SS, 4, number of chip-select outputs (1..16)
SEL_W, 2, width of ss_sel_i; must satisfy 2**SEL_W >= NUM_SS
DIV_W, 12, width of baudratedivisor_i (PCLK cycles per SPI bit)
LEN_W, 5, width of frame_len_i (bits per frame, 1..2**LEN_W-1)
SETUP_CYC, 1, PCLK cycles CS is low before the first bit period (0 allowed)
HOLD_CYC, 1, PCLK cycles CS stays low after the last bit period (0 allowed)

Ports:
PCLK  in  1  system clock, all logic on rising edge
PRESET_n  in  1  synchronous active-low reset, sampled on the PCLK rising edge
mstr_i  in  1  master mode enable
spiswai_i  in  1  SPI stop-in-wait request
spi_mode_i  in  2  00 = run, 01 = wait, others = stop
send_data_i  in  1  transfer request (level, sampled each cycle)
ss_sel_i  in  SEL_W  target slave index
baudratedivisor_i  in  DIV_W  PCLK cycles per SPI bit
frame_len_i  in  LEN_W  bits per frame
cont_i  in  1  continuous mode: hold CS across chained frames
ss_o  out  NUM_SS  active-low chip selects, registered
tip_o  out  1  transfer in progress
receive_data_o  out  1  one-cycle frame-complete strobe, registered
err_o  out  1  one-cycle strobe, illegal request rejected

Behaviour:
- en = mstr_i & ~spiswai_i & (spi_mode_i==00 | spi_mode_i==01).
- Reset (PRESET_n low at a rising edge) sets: state IDLE, ss_o all ones, receive_data_o 0, err_o 0, counters 0. Reset takes precedence over every other event, including mid-transfer; there is no receive strobe on reset.
- tip_o = ~&ss_o, combinational from the registered ss_o.
- ss_o is all ones or has exactly one bit low at any time.
- States: IDLE, SETUP, XFER, HOLD.
- IDLE, when send_data_i & en:
  - If baudratedivisor_i==0, frame_len_i==0 or ss_sel_i>=NUM_SS: err_o=1 for one cycle, stay IDLE, ss_o unchanged.
  - Otherwise latch sel, div and len; target = len*div (width DIV_W+LEN_W, no overflow possible); ss_o[sel] goes 0 at this edge.
  - Next state is SETUP if SETUP_CYC>0, else XFER.
- SETUP: runs exactly SETUP_CYC cycles, then XFER with count=0.
- XFER: count runs 0..target-1, one step per cycle. In the cycle with count==target-1:
  - If cont_i & send_data_i & en and the new request is legal with ss_sel_i==latched sel: relatch div and len, restart XFER at count 0. CS stays low.
  - Otherwise go to HOLD, or to IDLE if HOLD_CYC==0. A chained request with a different sel is not chained; it is served normally from IDLE after the frame completes.
- receive_data_o = 1 for exactly one cycle: the cycle immediately after each frame's last XFER cycle.
- HOLD: runs HOLD_CYC cycles with CS low; the final edge sets ss_o all ones and enters IDLE.
- IDLE accepts a new request in the first cycle ss_o is all ones.
- send_data_i in SETUP/HOLD, or in XFER other than the last cycle, is ignored.
- en falling in SETUP, XFER or HOLD aborts: next edge ss_o all ones, state IDLE, no receive strobe.
- Inputs other than en, send_data_i, cont_i and ss_sel_i are not re-sampled mid-frame.
- Single frame: CS is low for SETUP_CYC + len*div + HOLD_CYC cycles.

Decomposition:
- Package spi_ss_pkg holds:
  - state enum (IDLE/SETUP/XFER/HOLD)
  - SPI_RUN=2'b00 and SPI_WAIT=2'b01 constants
  - a function for the request-legality check
- Sub-module ss_frame_timer: loadable up-counter with a target input, start/clear controls, and a last-cycle flag. It is shared by the SETUP, XFER and HOLD phases.
- The controller FSM, CS decode and output registers stay in the top module.

Test Plan:
1. NUM_SS=4, SETUP=1, HOLD=1; div=4, len=8, sel=2, one send_data_i pulse -> ss_o=4'b1011 for 34 cycles, tip_o high the same 34 cycles, receive_data_o single pulse in cycle 34 (cycle 1 = first CS low), then ss_o=4'b1111.
2. Same setup with cont_i=1 and send_data_i held high -> ss_o=4'b1011 low continuously for 66 cycles, receive_data_o pulses in cycles 34 and 66, no CS glitch between frames.
3. spiswai_i raised in cycle 10 of test 1 -> ss_o=4'b1111 on the next edge, no receive_data_o pulse; a fresh request afterwards completes normally.
4. div=0, or sel=5 with NUM_SS=4 -> err_o one-cycle pulse, ss_o stays 4'b1111, tip_o 0.
5. PRESET_n low for one edge in cycle 20 of a frame -> at that edge ss_o=4'b1111, receive_data_o 0, state IDLE; no strobe follows.
6. spi_mode_i=2'b10, or mstr_i=0, with send_data_i=1 -> no CS activity and no err_o. Also run with SETUP=0, HOLD=0, div=1, len=1 -> CS low exactly 1 cycle, strobe in cycle 2.
